// File: rtl/gsim_rd_sched_if.sv
// Handshake bundle between gsim_rd_sched, the matrix memory and the solve datapath.
// master = scheduler view, slave = environment (memory + datapath) view.
interface gsim_rd_sched_if;
   logic         i_start;
   logic [4:0]   i_matrix_num;
   logic         o_busy;
   logic         o_done;
   logic         o_err;
   logic         o_mem_rreq;
   logic [9:0]   o_mem_addr;
   logic         i_mem_rrdy;
   logic [255:0] i_mem_dout;
   logic         i_mem_dout_vld;
   logic         o_row_vld;
   logic [255:0] o_row_data;
   logic [4:0]   o_row_mat;
   logic [3:0]   o_row_iter;
   logic [4:0]   o_row_col;
   logic         o_row_last;
   logic         i_row_rdy;

   modport master (
      input  i_start, i_matrix_num, i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_row_rdy,
      output o_busy, o_done, o_err, o_mem_rreq, o_mem_addr,
      output o_row_vld, o_row_data, o_row_mat, o_row_iter, o_row_col, o_row_last
   );

   modport slave (
      output i_start, i_matrix_num, i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_row_rdy,
      input  o_busy, o_done, o_err, o_mem_rreq, o_mem_addr,
      input  o_row_vld, o_row_data, o_row_mat, o_row_iter, o_row_col, o_row_last
   );
endinterface

// File: rtl/gsim_rd_sched.sv
// Read scheduler: issues b row + NUM_ITER sweeps of 16 columns per matrix, credit-throttled
// against a small return FIFO that hands tagged rows to the datapath in order.
module gsim_rd_sched #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned NUM_ITER   = 16,
   parameter int unsigned MAT_STRIDE = 17
) (
   input logic             i_clk,
   input logic             i_reset,
   gsim_rd_sched_if.master bus
);
   localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW     = PtrW + 1;
   localparam logic [3:0]  IterLast = 4'(NUM_ITER - 1);
   localparam logic [4:0]  ColB     = 5'd16;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   typedef struct packed {
      logic [4:0] mat;
      logic [3:0] iter;
      logic [4:0] col;
   } pos_t;

   localparam pos_t PosFirst = '{mat: 5'd0, iter: 4'd0, col: ColB};

   // Shared by issue and return sides so tags track addresses exactly.
   function automatic pos_t next_pos(pos_t p);
      pos_t n;
      n = p;
      if (p.col == ColB) begin
         n.col  = 5'd0;
         n.iter = 4'd0;
      end else if (p.col == 5'd15) begin
         if (p.iter == IterLast) begin
            n.mat  = p.mat + 5'd1;
            n.iter = 4'd0;
            n.col  = ColB;
         end else begin
            n.iter = p.iter + 4'd1;
            n.col  = 5'd0;
         end
      end else begin
         n.col = p.col + 5'd1;
      end
      return n;
   endfunction

   state_e            state_q, state_d;
   logic [4:0]        mat_num_q, mat_num_d;
   pos_t              iss_q, iss_d;
   pos_t              ret_q, ret_d;
   logic [CntW-1:0]   outst_q, outst_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic              err_q, err_d;

   logic [255:0]      data_mem [FIFO_DEPTH];
   logic [14:0]       tag_mem  [FIFO_DEPTH];

   logic              credit_ok, rreq, accept, push, stray, pop, iss_last, ret_last_row;
   logic [14:0]       head_tag;

   assign credit_ok    = ({1'b0, outst_q} + {1'b0, cnt_q}) < (CntW + 1)'(FIFO_DEPTH);
   assign rreq         = (state_q == StIssue) && credit_ok;
   assign accept       = rreq && bus.i_mem_rrdy;
   assign push         = bus.i_mem_dout_vld && (outst_q != '0);
   assign stray        = bus.i_mem_dout_vld && (outst_q == '0);
   assign pop          = (cnt_q != '0) && bus.i_row_rdy;
   assign iss_last     = (iss_q.col == 5'd15) && (iss_q.iter == IterLast) &&
                         (iss_q.mat == mat_num_q - 5'd1);
   assign ret_last_row = (ret_q.col == 5'd15) && (ret_q.iter == IterLast);

   always_comb begin
      state_d   = state_q;
      mat_num_d = mat_num_q;
      iss_d     = iss_q;
      ret_d     = ret_q;
      outst_d   = outst_q;
      cnt_d     = cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      err_d     = err_q | stray;

      if (accept) iss_d = next_pos(iss_q);
      if (push)   ret_d = next_pos(ret_q);

      case ({accept, push})
         2'b10:   outst_d = outst_q + CntW'(1);
         2'b01:   outst_d = outst_q - CntW'(1);
         default: outst_d = outst_q;
      endcase

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

      unique case (state_q)
         StIdle: begin
            if (bus.i_start) begin
               mat_num_d = bus.i_matrix_num;
               iss_d     = PosFirst;
               ret_d     = PosFirst;
               state_d   = (bus.i_matrix_num == 5'd0) ? StDone : StIssue;
            end
         end
         StIssue: if (accept && iss_last) state_d = StDrain;
         StDrain: if ((outst_q == '0) && (cnt_q == '0)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= StIdle;
         mat_num_q <= '0;
         iss_q     <= '0;
         ret_q     <= '0;
         outst_q   <= '0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mat_num_q <= mat_num_d;
         iss_q     <= iss_d;
         ret_q     <= ret_d;
         outst_q   <= outst_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         err_q     <= err_d;
      end
   end

   // Storage needs no reset: head outputs are gated by o_row_vld.
   always_ff @(posedge i_clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= bus.i_mem_dout;
         tag_mem[wr_ptr_q]  <= {ret_q, ret_last_row};
      end
   end

   assign head_tag        = bus.o_row_vld ? tag_mem[rd_ptr_q] : '0;
   assign bus.o_row_vld   = (cnt_q != '0);
   assign bus.o_row_data  = bus.o_row_vld ? data_mem[rd_ptr_q] : '0;
   assign bus.o_row_mat   = head_tag[14:10];
   assign bus.o_row_iter  = head_tag[9:6];
   assign bus.o_row_col   = head_tag[5:1];
   assign bus.o_row_last  = head_tag[0];
   assign bus.o_mem_rreq  = rreq;
   assign bus.o_mem_addr  = 10'(32'(iss_q.mat) * MAT_STRIDE + 32'(iss_q.col));
   assign bus.o_busy      = (state_q == StIssue) || (state_q == StDrain);
   assign bus.o_done      = (state_q == StDone);
   assign bus.o_err       = err_q;
endmodule

// File: tb/tb_gsim_rd_sched.sv
// Directed bench for gsim_rd_sched: scenario table plus reset, empty-job and stray-return sequences.
module tb_gsim_rd_sched;
   localparam int Depth = 4;

   typedef struct {
      int mat_num;
      int lat;
      bit rrdy_tog;
      int stall_at;
      int stall_len;
      int exp_reqs;
      int exp_rows;
      int exp_first_addr;   // first address issued for the last matrix
   } vec_t;

   typedef struct {
      int         due;
      logic [9:0] addr;
      int         idx;
   } ret_t;

   logic clk = 1'b0;
   logic rst;
   int   vec_cnt = 0;
   int   err_cnt = 0;
   ret_t rq[$];
   vec_t vecs[5];

   always #5 clk = ~clk;

   gsim_rd_sched_if bus ();

   gsim_rd_sched #(
      .FIFO_DEPTH(Depth),
      .NUM_ITER  (16),
      .MAT_STRIDE(17)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [270:0] act, input logic [270:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] pat(input int idx, input logic [9:0] addr);
      logic [15:0] w;
      w = {6'(idx), addr};
      return {16{w}};
   endfunction

   // Row k of the overall read sequence: 257 rows per matrix, b row first.
   task automatic exp_row(input int k, output logic [4:0] m, output logic [3:0] it,
                          output logic [4:0] c, output logic [9:0] a, output logic l);
      int r;
      int mi;
      r  = k % 257;
      mi = k / 257;
      m  = 5'(mi);
      if (r == 0) begin
         c  = 5'd16;
         it = 4'd0;
      end else begin
         it = 4'((r - 1) / 16);
         c  = 5'((r - 1) % 16);
      end
      a = 10'(mi * 17 + int'(c));
      l = (r == 256);
   endtask

   task automatic run_vec(input vec_t v, input bit exp_err, input string nm);
      int cyc, acc, rows, bad_addr, bad_rows, hold_bad, stab_bad, max_fl;
      int done_cyc, last_pop, first_addr, first_idx, lasts, extra_done;
      bit hold_prev, stab_prev;
      logic [9:0]   prev_addr, ea;
      logic [270:0] row_now, row_prev, row_first, row_last_seen;
      logic [4:0]   em, ec;
      logic [3:0]   ei;
      logic         el;
      ret_t         r;
      cyc = 0; acc = 0; rows = 0; bad_addr = 0; bad_rows = 0; hold_bad = 0; stab_bad = 0;
      max_fl = 0; done_cyc = -1; last_pop = -1; first_addr = -1; lasts = 0; extra_done = 0;
      hold_prev = 0; stab_prev = 0; prev_addr = '0; row_prev = '0;
      row_first = '0; row_last_seen = '0;
      first_idx = (v.mat_num - 1) * 257;
      rq.delete();

      bus.i_matrix_num = 5'(v.mat_num);
      bus.i_start      = 1'b1;
      step();
      bus.i_start = 1'b0;
      check({nm, "_busy_after_start"}, 271'(bus.o_busy), 271'(1));

      while (cyc < 20000) begin
         if (bus.o_done) begin
            done_cyc = cyc;
            break;
         end
         if (hold_prev && bus.o_mem_rreq && (bus.o_mem_addr !== prev_addr)) hold_bad++;
         row_now = {bus.o_row_mat, bus.o_row_iter, bus.o_row_col, bus.o_row_last,
                    bus.o_row_data};
         if (stab_prev && (row_now !== row_prev)) stab_bad++;

         bus.i_mem_rrdy   = v.rrdy_tog ? (cyc % 2 == 0) : 1'b1;
         bus.i_row_rdy    = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
         bus.i_start      = (cyc == 30);
         bus.i_matrix_num = (cyc == 30) ? 5'd7 : 5'(v.mat_num);
         if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            bus.i_mem_dout_vld = 1'b1;
            bus.i_mem_dout     = pat(r.idx, r.addr);
         end else begin
            bus.i_mem_dout_vld = 1'b0;
            bus.i_mem_dout     = '0;
         end

         if (bus.o_mem_rreq && bus.i_mem_rrdy) begin
            exp_row(acc, em, ei, ec, ea, el);
            if (bus.o_mem_addr !== ea) bad_addr++;
            if (acc == first_idx) first_addr = int'(bus.o_mem_addr);
            rq.push_back('{due: cyc + v.lat, addr: bus.o_mem_addr, idx: acc});
            acc++;
         end
         hold_prev = bus.o_mem_rreq && !bus.i_mem_rrdy;
         prev_addr = bus.o_mem_addr;
         if (acc - rows > max_fl) max_fl = acc - rows;

         if (bus.o_row_vld && bus.i_row_rdy) begin
            exp_row(rows, em, ei, ec, ea, el);
            if (row_now !== {em, ei, ec, el, pat(rows, ea)}) bad_rows++;
            if (rows == 0) row_first = row_now;
            row_last_seen = row_now;
            lasts += int'(bus.o_row_last);
            rows++;
            last_pop = cyc;
         end
         stab_prev = bus.o_row_vld && !bus.i_row_rdy;
         row_prev  = row_now;
         step();
         cyc++;
      end
      bus.i_start        = 1'b0;
      bus.i_mem_dout_vld = 1'b0;
      bus.i_row_rdy      = 1'b1;

      check({nm, "_done_seen"},       271'(done_cyc >= 0), 271'(1));
      check({nm, "_requests"},        271'(acc), 271'(v.exp_reqs));
      check({nm, "_rows"},            271'(rows), 271'(v.exp_rows));
      check({nm, "_bad_addrs"},       271'(bad_addr), 271'(0));
      check({nm, "_bad_rows"},        271'(bad_rows), 271'(0));
      check({nm, "_addr_hold_errs"},  271'(hold_bad), 271'(0));
      check({nm, "_row_stable_errs"}, 271'(stab_bad), 271'(0));
      check({nm, "_inflight_le_depth"}, 271'(max_fl <= Depth), 271'(1));
      check({nm, "_first_addr_last_mat"}, 271'(first_addr), 271'(v.exp_first_addr));
      check({nm, "_first_tag"}, 271'(row_first[270:257]), 271'({5'd0, 4'd0, 5'd16}));
      check({nm, "_last_tag"}, 271'(row_last_seen[270:256]),
            271'({5'(v.mat_num - 1), 4'd15, 5'd15, 1'b1}));
      check({nm, "_last_flags"},      271'(lasts), 271'(v.mat_num));
      check({nm, "_done_after_pop"},  271'(done_cyc > last_pop), 271'(1));
      check({nm, "_no_leftover_ret"}, 271'(rq.size()), 271'(0));
      check({nm, "_err"},             271'(bus.o_err), 271'(exp_err));
      for (int i = 0; i < 3; i++) begin
         step();
         extra_done += int'(bus.o_done);
      end
      check({nm, "_single_done"}, 271'(extra_done), 271'(0));
      check({nm, "_idle_quiet"},  271'({bus.o_busy, bus.o_mem_rreq, bus.o_row_vld}), 271'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int acc;
      int cyc;
      ret_t r;
      vecs[0] = '{1, 1, 1'b0, -1,  0, 257, 257, 16};
      vecs[1] = '{3, 1, 1'b0, -1,  0, 771, 771, 50};
      vecs[2] = '{1, 3, 1'b0, 40, 20, 257, 257, 16};
      vecs[3] = '{1, 1, 1'b1, -1,  0, 257, 257, 16};
      vecs[4] = '{2, 2, 1'b1, 100, 20, 514, 514, 33};

      rst = 1'b1;
      bus.i_start = 1'b0;
      bus.i_matrix_num = '0;
      bus.i_mem_rrdy = 1'b0;
      bus.i_mem_dout = '0;
      bus.i_mem_dout_vld = 1'b0;
      bus.i_row_rdy = 1'b1;
      step();
      step();
      check("rst_busy",     271'(bus.o_busy), 271'(0));
      check("rst_done",     271'(bus.o_done), 271'(0));
      check("rst_err",      271'(bus.o_err), 271'(0));
      check("rst_rreq",     271'(bus.o_mem_rreq), 271'(0));
      check("rst_row_vld",  271'(bus.o_row_vld), 271'(0));
      check("rst_addr",     271'(bus.o_mem_addr), 271'(0));
      check("rst_row_data", 271'(bus.o_row_data), 271'(0));
      check("rst_row_tags", 271'({bus.o_row_mat, bus.o_row_iter, bus.o_row_col, bus.o_row_last}),
            271'(0));
      rst = 1'b0;
      step();

      for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

      // Empty job: done the cycle after start, no requests.
      bus.i_matrix_num = 5'd0;
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      check("zero_done",      271'(bus.o_done), 271'(1));
      check("zero_rreq",      271'(bus.o_mem_rreq), 271'(0));
      step();
      check("zero_done_once", 271'(bus.o_done), 271'(0));
      check("zero_idle",      271'({bus.o_busy, bus.o_mem_rreq}), 271'(0));

      // Reset after request 100, then two late returns land as strays.
      rq.delete();
      acc = 0;
      cyc = 0;
      bus.i_matrix_num = 5'd1;
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      while (acc < 100 && cyc < 2000) begin
         bus.i_mem_rrdy = 1'b1;
         bus.i_row_rdy  = 1'b1;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            bus.i_mem_dout_vld = 1'b1;
            bus.i_mem_dout     = pat(r.idx, r.addr);
         end else begin
            bus.i_mem_dout_vld = 1'b0;
         end
         if (bus.o_mem_rreq) begin
            rq.push_back('{due: cyc + 3, addr: bus.o_mem_addr, idx: acc});
            acc++;
         end
         step();
         cyc++;
      end
      check("rst_mid_reached_100", 271'(acc), 271'(100));
      check("rst_mid_err_before",  271'(bus.o_err), 271'(0));
      rst = 1'b1;
      bus.i_mem_dout_vld = 1'b0;
      rq.delete();
      step();
      rst = 1'b0;
      check("rst_mid_fifo_empty", 271'(bus.o_row_vld), 271'(0));
      check("rst_mid_idle",       271'({bus.o_busy, bus.o_mem_rreq}), 271'(0));
      for (int i = 0; i < 2; i++) begin
         bus.i_mem_dout_vld = 1'b1;
         bus.i_mem_dout = '1;
         step();
      end
      bus.i_mem_dout_vld = 1'b0;
      step();
      check("stray_err",       271'(bus.o_err), 271'(1));
      check("stray_dropped",   271'(bus.o_row_vld), 271'(0));
      check("stray_quiet",     271'({bus.o_busy, bus.o_done, bus.o_mem_rreq}), 271'(0));

      run_vec(vecs[0], 1'b1, "rerun");

      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("err_cleared_by_reset", 271'(bus.o_err), 271'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
